// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side packer: FSM state encoding and the
// default values of the packer parameters.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DSIZE   = 8;   // FIFO word width in bits
    localparam int DEF_NBYTES  = 4;   // FIFO words packed per output word
    localparam int DEF_TIMEOUT = 16;  // idle cycles before a partial word is emitted

    // FILL: collecting FIFO words into lanes.
    // HOLD: presenting a packed word downstream until it is accepted.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fifo_state_e;

endpackage

// File: rtl/fifo_rd_packer_idle_timer.sv
// -----------------------------------------------------------------------------
// idle_timer
// Counts idle cycles while enabled. o_expire pulses in the enabled cycle in
// which the count sits at TIMEOUT-1, i.e. on the TIMEOUT-th idle cycle.
// i_clr has priority over i_en and suppresses o_expire.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_en     - count this cycle
//   i_clr    - return the count to zero
//   o_expire - TIMEOUT-th consecutive enabled cycle (combinational)
// -----------------------------------------------------------------------------
module idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign o_expire = i_en && !i_clr && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            // Wrap on expiry so the count is already zero when filling resumes.
            cnt_d = o_expire ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Pops words from a show-ahead FIFO and packs NBYTES of them into one wide
// output word (lane 0 = LSBs = first word popped). A partially filled word is
// emitted after TIMEOUT idle cycles or on i_flush. Unfilled lanes read zero.
//
// Handshake: the output side is strict valid/ready. o_valid rises only in HOLD
// and, once high, o_data/o_count stay stable and o_valid stays high until the
// cycle in which i_ready is also high; the word transfers on that rising edge.
// The FIFO side pops on every rising edge where o_fifo_rd is high, and
// o_fifo_rd is never high while i_fifo_rempty is high.
//
// Ports:
//   i_clk, i_rst     - clock (rising edge), asynchronous active-high reset
//   i_fifo_rempty    - FIFO empty flag
//   i_fifo_rdata     - FIFO head word (valid while not empty)
//   o_fifo_rd        - FIFO pop request
//   i_flush          - emit the partial word now
//   o_valid, i_ready - output handshake
//   o_data           - packed word
//   o_count          - number of valid lanes in o_data
//   o_state          - current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE   = DEF_DSIZE,
    parameter int NBYTES  = DEF_NBYTES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_fifo_rempty,
    input  logic [DSIZE-1:0]             i_fifo_rdata,
    output logic                         o_fifo_rd,
    input  logic                         i_flush,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NBYTES*DSIZE-1:0]      o_data,
    output logic [$clog2(NBYTES+1)-1:0]  o_count,
    output fifo_state_e                  o_state
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int DW = NBYTES * DSIZE;

    fifo_state_e    state_q, state_d;
    logic [CW-1:0]  idx_q, idx_d;     // lanes filled; doubles as o_count in HOLD
    logic [DW-1:0]  data_q, data_d;   // lanes above idx are kept at zero

    logic pop;
    logic tmr_en;
    logic tmr_clr;
    logic expire;

    // Reset gating keeps the pop request low while reset is held, even though
    // the state register already reads FILL.
    assign pop     = !i_rst && (state_q == FILL) && !i_fifo_rempty;
    assign tmr_en  = (state_q == FILL) && (idx_q != '0) && !pop;
    // Clearing throughout HOLD guarantees a zero timer when FILL resumes.
    assign tmr_clr = pop || (state_q == HOLD);

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (tmr_en),
        .i_clr    (tmr_clr),
        .o_expire (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (pop) begin
                    for (int l = 0; l < NBYTES; l++) begin
                        if (idx_q == CW'(l)) begin
                            data_d[l*DSIZE +: DSIZE] = i_fifo_rdata;
                        end
                    end
                    idx_d = idx_q + CW'(1);
                    // A pop with flush keeps the popped word in the emission.
                    if ((idx_q == CW'(NBYTES - 1)) || i_flush) begin
                        state_d = HOLD;
                    end
                end else if ((idx_q != '0) && (i_flush || expire)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign o_fifo_rd = pop;
    assign o_valid   = (state_q == HOLD);
    assign o_data    = o_valid ? data_q : '0;
    assign o_count   = o_valid ? idx_q  : '0;
    assign o_state   = state_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Bench for fifo_rd_packer with DSIZE=8, NBYTES=4, TIMEOUT=16 and a queue-based
// show-ahead FIFO. Reference model: a queue of collected words, an idle-cycle
// count and a holding flag, advanced once per cycle from the packing rules.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int DSIZE   = 8;
    localparam int NB      = 4;
    localparam int TIMEOUT = 16;
    localparam int DW      = NB * DSIZE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst = 1'b1;
    logic              i_fifo_rempty = 1'b1;
    logic [DSIZE-1:0]  i_fifo_rdata = '0;
    logic              o_fifo_rd;
    logic              i_flush = 1'b0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [DW-1:0]     o_data;
    logic [2:0]        o_count;
    fifo_state_e       o_state;

    fifo_rd_packer #(
        .DSIZE   (DSIZE),
        .NBYTES  (NB),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_fifo_rempty (i_fifo_rempty),
        .i_fifo_rdata  (i_fifo_rdata),
        .o_fifo_rd     (o_fifo_rd),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_count       (o_count),
        .o_state       (o_state)
    );

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [DSIZE-1:0] fifo_q[$];   // show-ahead FIFO contents
    logic [DSIZE-1:0] exp_q[$];    // popped words awaiting emission, in order
    logic [DSIZE-1:0] acc[$];      // model: words collected in the current word
    bit               m_hold = 1'b0;
    int               m_idle = 0;

    logic          obs_valid, obs_rd;
    logic [DW-1:0] obs_data;
    logic [2:0]    obs_count;
    logic [DW-1:0] last_hs_data = '0;
    logic [2:0]    last_hs_count = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- one clock cycle ----------------
    task automatic step(input logic rst, input logic flush, input logic ready);
        logic [DSIZE-1:0] head;
        logic             er, ev;
        logic [2:0]       ec;
        logic [DW-1:0]    ed;
        @(negedge clk);
        i_rst         = rst;
        i_flush       = flush;
        i_ready       = ready;
        i_fifo_rempty = (fifo_q.size() == 0);
        i_fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        er = !rst && !m_hold && (fifo_q.size() != 0);
        ev = !rst && m_hold;
        ec = '0;
        ed = '0;
        if (ev) begin
            for (int i = 0; i < acc.size(); i++) ed |= DW'(acc[i]) << (DSIZE * i);
            ec = 3'(acc.size());
        end
        n_tests++;
        if ({o_fifo_rd, o_valid, o_count, o_data} !== {er, ev, ec, ed}) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t: got rd=%b valid=%b count=%0d data=%h, expected rd=%b valid=%b count=%0d data=%h",
                     $time, o_fifo_rd, o_valid, o_count, o_data, er, ev, ec, ed);
        end
        check("state_dbg", 64'(o_state), 64'(ev ? HOLD : FILL));
        obs_valid = o_valid;
        obs_rd    = o_fifo_rd;
        obs_data  = o_data;
        obs_count = o_count;
        head      = i_fifo_rdata;
        if (o_fifo_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        // reference model advance
        if (rst) begin
            acc.delete();
            exp_q.delete();
            m_hold = 1'b0;
            m_idle = 0;
        end else if (!m_hold) begin
            if (er) begin
                acc.push_back(head);
                exp_q.push_back(head);
                m_idle = 0;
                if (acc.size() == NB || flush) m_hold = 1'b1;
            end else if (acc.size() != 0) begin
                if (flush) m_hold = 1'b1;
                else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) m_hold = 1'b1;
                end
            end
        end else if (ready) begin
            // scoreboard: accepted lanes must be the popped words in order
            for (int i = 0; i < int'(o_count) && i < NB; i++) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_extra_lane t=%0t: got lane %0d=%h, expected no word", $time, i, o_data[DSIZE*i +: DSIZE]);
                end else begin
                    logic [DSIZE-1:0] e;
                    e = exp_q.pop_front();
                    if (o_data[DSIZE*i +: DSIZE] !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard_lane t=%0t: got lane %0d=%h, expected %h", $time, i, o_data[DSIZE*i +: DSIZE], e);
                    end
                end
            end
            last_hs_data  = o_data;
            last_hs_count = o_count;
            acc.delete();
            m_hold = 1'b0;
            m_idle = 0;
        end
    endtask

    // Steps with i_ready=1 until o_valid is seen; lat=-1 if the budget expires.
    task automatic wait_valid(input int max, output int lat);
        lat = -1;
        for (int c = 0; c < max; c++) begin
            step(1'b0, 1'b0, 1'b1);
            if (obs_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid_timeout t=%0t: got no o_valid in %0d cycles, expected o_valid", $time, max);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [DW-1:0] words;
        int            n;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_count;
        int            exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat;
        int valids;

        vecs[0] = '{words: 32'h44332211, n: 4, exp_data: 32'h44332211, exp_count: 3'd4, exp_lat: 4};
        vecs[1] = '{words: 32'h0000BBAA, n: 2, exp_data: 32'h0000BBAA, exp_count: 3'd2, exp_lat: 18};
        vecs[2] = '{words: 32'h00030201, n: 3, exp_data: 32'h00030201, exp_count: 3'd3, exp_lat: 19};
        vecs[3] = '{words: 32'h0000005A, n: 1, exp_data: 32'h0000005A, exp_count: 3'd1, exp_lat: 17};

        // reset state
        step(1'b1, 1'b0, 1'b0);
        check("reset_outputs", 64'({o_fifo_rd, o_valid, o_count, o_data}), 64'(0));
        step(1'b1, 1'b0, 1'b0);

        // table: full word, timed-out partials
        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].n; k++) fifo_q.push_back(vecs[v].words[DSIZE*k +: DSIZE]);
            wait_valid(40, lat);
            check("vec_latency", 64'(lat), 64'(vecs[v].exp_lat));
            check("vec_data", 64'({obs_count, obs_data}), 64'({vecs[v].exp_count, vecs[v].exp_data}));
            step(1'b0, 1'b0, 1'b1);
            check("vec_valid_one_cycle", 64'(obs_valid), 64'(0));
        end

        // backpressure: 8 words, downstream stalls 10 cycles in HOLD
        for (int k = 0; k < 8; k++) fifo_q.push_back(8'h10 + 8'(k));
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b0);
            check("stall_hold", 64'({obs_rd, obs_valid, obs_count, obs_data}), 64'({1'b0, 1'b1, 3'd4, 32'h13121110}));
        end
        wait_valid(5, lat);
        wait_valid(10, lat);
        check("stall_second_word", 64'({obs_count, obs_data}), 64'({3'd4, 32'h17161514}));
        step(1'b0, 1'b0, 1'b1);
        check("stall_fifo_drained", 64'(fifo_q.size()), 64'(0));

        // flush on the 4th pop, then flush with nothing collected
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'hC1 + 8'(k));
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        wait_valid(3, lat);
        check("flush_full_word", 64'({obs_count, obs_data}), 64'({3'd4, 32'hC4C3C2C1}));
        valids = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 1'b1);
            valids += int'(obs_valid);
        end
        check("flush_idx0_ignored", 64'(valids), 64'(0));

        // flush coinciding with a pop (3rd word) and flush without a pop
        for (int k = 0; k < 3; k++) fifo_q.push_back(8'hD1 + 8'(k));
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        wait_valid(3, lat);
        check("flush_with_pop", 64'({obs_count, obs_data}), 64'({3'd3, 32'h00D3D2D1}));
        fifo_q.push_back(8'hE1);
        fifo_q.push_back(8'hE2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        wait_valid(3, lat);
        check("flush_partial", 64'({obs_count, obs_data}), 64'({3'd2, 32'h0000E2E1}));

        // reset mid-fill discards the partial word
        fifo_q.push_back(8'h77);
        fifo_q.push_back(8'h88);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'h01 + 8'(k));
        step(1'b1, 1'b0, 1'b1);
        check("reset_mid_fill", 64'({obs_rd, obs_valid, obs_count, obs_data}), 64'(0));
        wait_valid(10, lat);
        check("reset_then_word", 64'({obs_count, obs_data}), 64'({3'd4, 32'h04030201}));

        // slow trickle: one word every 10 cycles never times out
        valids = 0;
        for (int k = 0; k < 3; k++) begin
            fifo_q.push_back(8'hF0 + 8'(k));
            for (int c = 0; c < 10; c++) begin
                step(1'b0, 1'b0, 1'b1);
                valids += int'(obs_valid);
            end
        end
        check("trickle_no_timeout", 64'(valids), 64'(0));
        fifo_q.push_back(8'hF3);
        wait_valid(5, lat);
        check("trickle_word", 64'({obs_count, obs_data}), 64'({3'd4, 32'hF3F2F1F0}));
        step(1'b0, 1'b0, 1'b1);

        // randomized traffic in phases of differing push density
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 250; c++) begin
                if (fifo_q.size() < 20 && $urandom_range(0, 9) < (ph * 3 + 1))
                    fifo_q.push_back(8'($urandom_range(0, 255)));
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0);
            end
        end

        // drain: everything popped must eventually be emitted
        for (int c = 0; c < 200; c++) begin
            if (fifo_q.size() == 0 && acc.size() == 0 && !m_hold) break;
            step(1'b0, 1'b0, 1'b1);
        end
        check("drain_no_loss", 64'({fifo_q.size(), exp_q.size()}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
